// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: passive shadow of an HD44780-style 8-bit LCD bus.
// Decodes EN falling-edge transactions into instruction/data writes and
// keeps a 2x16 DDRAM image, address counter and display-control state.
// Optional macro LCD_RX_SYNC_EN: pass the bus through a 2-flop synchronizer
// before edge detection (adds 2 cycles to every latency).
module lcd_bus_receiver (
    input  logic       clk,
    input  logic       reset,
    input  logic       EN,
    input  logic       RS,
    input  logic       RW,
    input  logic [7:0] data,
    output logic [7:0] rd_data,
    input  logic [4:0] cell_addr,
    output logic [7:0] cell_char,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_id,
    output logic       cmd_strobe,
    output logic       data_strobe,
    output logic [1:0] err
);
    localparam int         CELLS = 32;
    localparam logic [7:0] BLANK = 8'h20;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEARING} state_t;

    // Bus view after optional synchronization
    logic       w_en;
    logic       w_rs;
    logic       w_rw;
    logic [7:0] w_data;

`ifdef LCD_RX_SYNC_EN
    logic [10:0] r_sync1;
    logic [10:0] r_sync2;

    // Two-flop synchronizer for the whole bus bundle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {EN, RS, RW, data};
            r_sync2 <= r_sync1;
        end
    end

    assign {w_en, w_rs, w_rw, w_data} = r_sync2;
`else
    assign {w_en, w_rs, w_rw, w_data} = {EN, RS, RW, data};
`endif

    logic       r_en_d;
    logic       r_rs;
    logic       r_rw;
    logic [7:0] r_data;
    logic       w_fall;

    // Capture RS/RW/data on every EN-high cycle; remember EN for edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en_d <= 1'b0;
            r_rs   <= 1'b0;
            r_rw   <= 1'b0;
            r_data <= 8'h00;
        end else begin
            r_en_d <= w_en;
            if (w_en) begin
                r_rs   <= w_rs;
                r_rw   <= w_rw;
                r_data <= w_data;
            end
        end
    end

    assign w_fall = r_en_d & ~w_en;

    // Next address counter value with the two-line HD44780 wrap
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            if (a == 7'h0F)      n = 7'h40;
            else if (a == 7'h4F) n = 7'h00;
            else                 n = a + 7'd1;
        end else begin
            if (a == 7'h00)      n = 7'h4F;
            else if (a == 7'h40) n = 7'h0F;
            else                 n = a - 7'd1;
        end
        return n;
    endfunction

    state_t     r_state;
    logic [4:0] r_clr_idx;
    logic [7:0] r_mem [0:CELLS-1];
    logic [6:0] r_ac;
    logic       r_entry_id;
    logic       r_disp;
    logic       r_cursor;
    logic       r_blink;
    logic       r_busy;
    logic       r_cmd_strobe;
    logic       r_data_strobe;
    logic [1:0] r_err;
    logic [7:0] r_rd_data;
    logic [7:0] r_cell_char;
    logic [4:0] w_ac_idx;

    assign w_ac_idx = {r_ac[6], r_ac[3:0]};

    // Transaction FSM: IDLE waits for an edge, EXEC applies it, CLEARING blanks cells
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_clr_idx     <= 5'd0;
            r_ac          <= 7'h00;
            r_entry_id    <= 1'b1;
            r_disp        <= 1'b0;
            r_cursor      <= 1'b0;
            r_blink       <= 1'b0;
            r_busy        <= 1'b0;
            r_cmd_strobe  <= 1'b0;
            r_data_strobe <= 1'b0;
            r_err         <= 2'b00;
            r_rd_data     <= 8'h00;
            for (int i = 0; i < CELLS; i++) begin
                r_mem[i] <= BLANK;
            end
        end else begin
            r_cmd_strobe  <= 1'b0;
            r_data_strobe <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fall) r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                    if (r_rw) begin
                        if (r_rs) begin
                            r_rd_data <= r_mem[w_ac_idx];
                            r_ac      <= ac_step(r_ac, r_entry_id);
                        end else begin
                            r_rd_data <= {1'b0, r_ac};
                        end
                    end else if (r_rs) begin
                        r_mem[w_ac_idx] <= r_data;
                        r_ac            <= ac_step(r_ac, r_entry_id);
                        r_data_strobe   <= 1'b1;
                    end else begin
                        // Every non-zero instruction byte is acknowledged
                        r_cmd_strobe <= |r_data;
                        casez (r_data)
                            8'b1???????: begin
                                if (r_data[5:4] == 2'b00) r_ac <= r_data[6:0];
                                else                      r_err[0] <= 1'b1;
                            end
                            8'b01??????, 8'b001?????: begin
                            end
                            8'b0001????: begin
                                if (!r_data[3]) r_ac <= ac_step(r_ac, r_data[2]);
                            end
                            8'b00001???: {r_disp, r_cursor, r_blink} <= r_data[2:0];
                            8'b000001??: r_entry_id <= r_data[1];
                            8'b0000001?: r_ac <= 7'h00;
                            8'b00000001: begin
                                r_ac       <= 7'h00;
                                r_entry_id <= 1'b1;
                                r_busy     <= 1'b1;
                                r_clr_idx  <= 5'd0;
                                r_state    <= S_CLEARING;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_CLEARING: begin
                    r_mem[r_clr_idx] <= BLANK;
                    r_clr_idx        <= r_clr_idx + 5'd1;
                    if (r_clr_idx == 5'd31) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // An edge arriving while a transaction is in flight is dropped
            if (w_fall && (r_state != S_IDLE)) begin
                r_err[1] <= 1'b1;
                if (r_rw && !r_rs) r_rd_data <= {1'b1, r_ac};
            end
        end
    end

    // Side-band registered read of one cell (old value on same-cycle write)
    always_ff @(posedge clk) begin
        if (reset) r_cell_char <= BLANK;
        else       r_cell_char <= r_mem[cell_addr];
    end

    assign rd_data     = r_rd_data;
    assign cell_char   = r_cell_char;
    assign busy        = r_busy;
    assign ac          = r_ac;
    assign disp_on     = r_disp;
    assign cursor_on   = r_cursor;
    assign blink_on    = r_blink;
    assign entry_id    = r_entry_id;
    assign cmd_strobe  = r_cmd_strobe;
    assign data_strobe = r_data_strobe;
    assign err         = r_err;
endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Testbench for lcd_bus_receiver: directed scenarios plus random traffic,
// checked against a cursor-position model with a strobe scoreboard.
module tb_lcd_bus_receiver;
    logic       clk = 1'b0;
    logic       reset;
    logic       EN, RS, RW;
    logic [7:0] data;
    logic [7:0] rd_data;
    logic [4:0] cell_addr;
    logic [7:0] cell_char;
    logic       busy;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on, entry_id;
    logic       cmd_strobe, data_strobe;
    logic [1:0] err;

    lcd_bus_receiver dut (
        .clk(clk), .reset(reset), .EN(EN), .RS(RS), .RW(RW), .data(data),
        .rd_data(rd_data), .cell_addr(cell_addr), .cell_char(cell_char),
        .busy(busy), .ac(ac), .disp_on(disp_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .entry_id(entry_id), .cmd_strobe(cmd_strobe),
        .data_strobe(data_strobe), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: cursor as linear position 0..31 (line*16 + column)
    logic [7:0] m_cells [32];
    int         m_pos;
    bit         m_inc;
    bit [2:0]   m_dcb;
    logic [1:0] m_err;

    function automatic logic [6:0] pos_ac(input int p);
        return (p < 16) ? 7'(p) : 7'(64 + p - 16);
    endfunction

    function automatic void m_step(input bit inc);
        m_pos = inc ? (m_pos + 1) % 32 : (m_pos + 31) % 32;
    endfunction

    typedef struct {
        bit         is_data;
        logic [6:0] ac;
        bit         id;
        bit [2:0]   dcb;
        bit         busy;
        logic [1:0] err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    function automatic void push_exp(input bit is_data, input bit bsy);
        exp_t e;
        e.is_data = is_data;
        e.ac      = pos_ac(m_pos);
        e.id      = m_inc;
        e.dcb     = m_dcb;
        e.busy    = bsy;
        e.err     = m_err;
        q.push_back(e);
    endfunction

    // Monitor: every strobe must match the oldest pending expectation
    always @(negedge clk) begin
        if (!reset && (cmd_strobe || data_strobe)) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", {30'd0, cmd_strobe, data_strobe}, 32'd0);
            end else begin
                mon_e = q.pop_front();
                chk("data_strobe", data_strobe, mon_e.is_data);
                chk("cmd_strobe", cmd_strobe, !mon_e.is_data);
                chk("strobe_ac", ac, mon_e.ac);
                chk("strobe_entry_id", entry_id, mon_e.id);
                chk("strobe_dcb", {disp_on, cursor_on, blink_on}, mon_e.dcb);
                chk("strobe_busy", busy, mon_e.busy);
                chk("strobe_err", err, mon_e.err);
                $display("txn %s ac=%02h id=%0d dcb=%03b busy=%0d err=%02b",
                         mon_e.is_data ? "DATA" : "INSTR", ac, entry_id,
                         {disp_on, cursor_on, blink_on}, busy, err);
            end
        end
    end

    task automatic drive(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        EN = 1'b1; RS = rs; RW = rw; data = d;
        @(negedge clk);
        EN = 1'b0; {RS, RW} = 2'($urandom); data = 8'($urandom);
    endtask

    task automatic settle();
        repeat (5) @(negedge clk);
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        if (busy) chk("busy_timeout", busy, 1'b0);
    endtask

    task automatic instr(input logic [7:0] d);
        int a;
        bit clr;
        clr = 0;
        a = int'(d[6:0]);
        if (d[7]) begin
            if (a < 16) m_pos = a;
            else if (a >= 64 && a < 80) m_pos = 16 + a - 64;
            else m_err[0] = 1'b1;
        end else if (d[6] || d[5]) begin
        end else if (d[4]) begin
            if (!d[3]) m_step(d[2]);
        end else if (d[3]) begin
            m_dcb = d[2:0];
        end else if (d[2]) begin
            m_inc = d[1];
        end else if (d[1]) begin
            m_pos = 0;
        end else if (d[0]) begin
            for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
            m_pos = 0; m_inc = 1; clr = 1;
        end
        if (d != 8'h00) push_exp(0, clr);
        drive(1'b0, 1'b0, d);
        settle();
    endtask

    task automatic wdata(input logic [7:0] d);
        m_cells[m_pos] = d;
        m_step(m_inc);
        push_exp(1, 0);
        drive(1'b1, 1'b0, d);
        settle();
    endtask

    task automatic rd(input logic rs);
        logic [7:0] e;
        if (rs) begin
            e = m_cells[m_pos];
            m_step(m_inc);
        end else begin
            e = {1'b0, pos_ac(m_pos)};
        end
        drive(rs, 1'b1, 8'($urandom));
        settle();
        chk(rs ? "rd_data_ddram" : "rd_data_status", rd_data, e);
        chk("rd_ac", ac, pos_ac(m_pos));
    endtask

    task automatic check_cells();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            cell_addr = 5'(i);
            @(negedge clk);
            chk($sformatf("cell_char[%0d]", i), cell_char, m_cells[i]);
        end
    endtask

    task automatic check_state();
        chk("ac", ac, pos_ac(m_pos));
        chk("entry_id", entry_id, m_inc);
        chk("dcb", {disp_on, cursor_on, blink_on}, m_dcb);
        chk("err", err, m_err);
        chk("busy", busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bcnt;
        int k;
        reset = 1'b1; EN = 1'b0; RS = 1'b0; RW = 1'b0; data = 8'h00; cell_addr = 5'd0;
        for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
        m_pos = 0; m_inc = 1; m_dcb = 3'b000; m_err = 2'b00;
        repeat (4) @(negedge clk);
        chk("reset_rd_data", rd_data, 8'h00);
        chk("reset_strobes", {cmd_strobe, data_strobe}, 2'b00);
        reset = 1'b0;
        check_state();
        check_cells();

        // Two data writes from address 0
        instr(8'h80); wdata(8'h41); wdata(8'h42);
        check_state();
        // Wrap from end of line 2 back to line 1
        instr(8'hCF); wdata(8'h5A); wdata(8'h5A);
        check_state();
        // Decrement across the line 2 -> line 1 boundary
        instr(8'h04); instr(8'hC0); wdata(8'h31);
        check_state();
        check_cells();
        // Null instruction produces no strobe and no change
        instr(8'h00);
        check_state();

        // Clear with a colliding data write while busy
        for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
        m_pos = 0; m_inc = 1;
        push_exp(0, 1);
        drive(1'b0, 1'b0, 8'h01);
        bcnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (c == 5) begin EN = 1'b1; RS = 1'b1; RW = 1'b0; data = 8'h55; end
            if (c == 6) EN = 1'b0;
        end
        m_err[1] = 1'b1;
        chk("clear_busy_cycles", bcnt, 32);
        settle();
        check_state();
        check_cells();

        // Display control, invalid DDRAM address, status read
        instr(8'h0F); instr(8'h95);
        check_state();
        rd(1'b0);

        // Randomized traffic
        for (int t = 0; t < 250; t++) begin
            k = $urandom_range(0, 9);
            if (k < 4)       wdata(8'($urandom_range(32, 126)));
            else if (k < 6)  rd(1'($urandom_range(0, 1)));
            else if (k == 6) instr({1'b1, 1'($urandom_range(0, 1)), 2'b00, 4'($urandom)});
            else if (k == 7 && $urandom_range(0, 7) == 0) instr(8'h01);
            else             instr(8'($urandom_range(2, 255)));
            if (t % 50 == 49) check_cells();
        end
        check_state();
        check_cells();
        chk("scoreboard_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
